// File: rtl/reg_shadow_pkg.sv
// rtl/reg_shadow_pkg.sv - shared types and constants for the register shadow latch
//
// Purpose: the FSM state encoding, the settle-counter width and a helper that
// gives the LSB position of one register inside the flat register bus.
package reg_shadow_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    ARM     = 2'd2,
    CAPTURE = 2'd3
  } state_e;

  localparam int CNT_WIDTH = 8;

  // LSB of register idx in a flat bus of registers that are width bits wide.
  function automatic int reg_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/cc_sync2.sv
// rtl/cc_sync2.sv - generic two-flop synchronizer
//
// Purpose: brings an asynchronous level into the clk domain.
// Ports:
//   clk   - destination clock
//   reset - asynchronous, active-low reset (clears both stages)
//   d     - asynchronous input, WIDTH bits
//   q     - synchronized output, WIDTH bits, two clk edges of latency
module cc_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/reg_shadow_latch.sv
// rtl/reg_shadow_latch.sv - clk-domain shadow copy of the bus-clocked register file
//
// Purpose: watches register bus write activity, waits for the bus to stay quiet
// for SETTLE_CYCLES clocks, then snapshots the whole flat register bus into a
// shadow copy (optionally only on the rising edge of vblank) so rendering logic
// sees values that are glitch-free and constant for a whole frame.
// Ports:
//   clk          - system clock
//   reset        - asynchronous, active-low reset
//   values_in    - live flat register bus (async to clk, stable while quiet)
//   bus_en       - register bus access enable (async)
//   bus_wr       - register bus write strobe (async, data committed on its fall)
//   vblank       - vertical blank flag (clk domain)
//   force_update - one-cycle request to capture once settled, ignoring vblank
//   values_out   - shadow copy, same packing as values_in
//   pending      - a write has ended that has not been captured yet
//   update_done  - one-cycle pulse in the cycle after a capture
module reg_shadow_latch
  import reg_shadow_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_REGS       = 16,
  parameter int SETTLE_CYCLES  = 4,
  parameter int SYNC_TO_VBLANK = 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DATA_WIDTH*NUM_REGS-1:0] values_in,
  input  logic                           bus_en,
  input  logic                           bus_wr,
  input  logic                           vblank,
  input  logic                           force_update,
  output logic [DATA_WIDTH*NUM_REGS-1:0] values_out,
  output logic                           pending,
  output logic                           update_done
);

  localparam int FLAT_W = DATA_WIDTH * NUM_REGS;
  localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD = CNT_WIDTH'(SETTLE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE     = CNT_WIDTH'(1);

  logic busy_raw;
  logic busy_s;

  assign busy_raw = bus_en & bus_wr;

  cc_sync2 #(.WIDTH(1)) u_busy_sync (
    .clk   (clk),
    .reset (reset),
    .d     (busy_raw),
    .q     (busy_s)
  );

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 busy_d_q, busy_d_d;
  logic                 vblank_d_q, vblank_d_d;
  logic                 force_req_q, force_req_d;
  logic                 pending_q, pending_d;
  logic                 update_done_q, update_done_d;
  logic [FLAT_W-1:0]    values_q, values_d;

  logic fall;
  logic vblank_rise;
  logic capture;

  assign fall        = busy_d_q & ~busy_s;
  assign vblank_rise = vblank & ~vblank_d_q;
  assign capture     = (state_q == CAPTURE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (busy_s) begin
          cnt_d = SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ARM;
          end
        end
      end
      ARM: begin
        // A new write beats vblank/force: the bus is moving again, so the
        // capture is pushed back until it has settled once more.
        if (busy_s) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LOAD;
        end else if ((SYNC_TO_VBLANK == 0) || force_req_q || vblank_rise) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        // A write ending in the capture cycle would otherwise leave pending
        // set with nothing scheduled to capture it.
        if (fall) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy_d_d      = busy_s;
    vblank_d_d    = vblank;
    update_done_d = capture;
    values_d      = capture ? values_in : values_q;
    // Set beats clear when a write ends in the capture cycle.
    pending_d     = fall ? 1'b1 : (capture ? 1'b0 : pending_q);
    force_req_d   = force_update | (force_req_q & ~capture);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      busy_d_q      <= 1'b0;
      vblank_d_q    <= 1'b0;
      force_req_q   <= 1'b0;
      pending_q     <= 1'b0;
      update_done_q <= 1'b0;
      values_q      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      busy_d_q      <= busy_d_d;
      vblank_d_q    <= vblank_d_d;
      force_req_q   <= force_req_d;
      pending_q     <= pending_d;
      update_done_q <= update_done_d;
      values_q      <= values_d;
    end
  end

  assign values_out  = values_q;
  assign pending     = pending_q;
  assign update_done = update_done_q;

endmodule

// File: tb/tb_reg_shadow_latch.sv
// tb/tb_reg_shadow_latch.sv - self-checking bench for reg_shadow_latch
module tb_reg_shadow_latch;
  import reg_shadow_pkg::*;

  localparam int DW = 16;
  localparam int NR = 16;
  localparam int SC = 4;
  localparam int W  = DW * NR;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  values_in;
  logic          bus_en, bus_wr, vblank, force_update;
  logic [W-1:0]  vo0, vo1;
  logic          pend0, pend1, done0, done1;

  always #5 clk = ~clk;

  reg_shadow_latch #(.DATA_WIDTH(DW), .NUM_REGS(NR), .SETTLE_CYCLES(SC), .SYNC_TO_VBLANK(0)) dut0 (
    .clk(clk), .reset(reset), .values_in(values_in), .bus_en(bus_en), .bus_wr(bus_wr),
    .vblank(vblank), .force_update(force_update), .values_out(vo0), .pending(pend0),
    .update_done(done0)
  );

  reg_shadow_latch #(.DATA_WIDTH(DW), .NUM_REGS(NR), .SETTLE_CYCLES(SC), .SYNC_TO_VBLANK(1)) dut1 (
    .clk(clk), .reset(reset), .values_in(values_in), .bus_en(bus_en), .bus_wr(bus_wr),
    .vblank(vblank), .force_update(force_update), .values_out(vo1), .pending(pend1),
    .update_done(done1)
  );

  int cyc = 0;
  int pulses0 = 0, pulses1 = 0;
  int last_done0 = -100, last_done1 = -100;
  int spur = 0;
  logic [W-1:0] prev0 = '0, prev1 = '0;
  logic reset_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done0) begin pulses0 <= pulses0 + 1; last_done0 <= cyc; end
    if (done1) begin pulses1 <= pulses1 + 1; last_done1 <= cyc; end
    if (reset && reset_prev) begin
      if (vo0 != prev0 && !done0) spur <= spur + 1;
      if (vo1 != prev1 && !done1) spur <= spur + 1;
    end
    prev0      <= vo0;
    prev1      <= vo1;
    reset_prev <= reset;
  end

  int errors = 0, checks = 0;
  int fall_cyc = 0;
  logic [W-1:0] sh0, sh1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Data is committed to the live bus when the strobe falls.
  task automatic do_write(input int idx, input logic [DW-1:0] val, input int hi);
    @(negedge clk);
    bus_en = 1'b1;
    bus_wr = 1'b1;
    repeat (hi) @(negedge clk);
    bus_wr = 1'b0;
    bus_en = 1'b0;
    values_in[reg_lsb(idx, DW) +: DW] = val;
    fall_cyc = cyc;
  endtask

  task automatic pulse_force();
    @(negedge clk);
    force_update = 1'b1;
    @(negedge clk);
    force_update = 1'b0;
  endtask

  task automatic vblank_pulse();
    @(negedge clk);
    vblank = 1'b1;
    repeat (3) @(negedge clk);
    vblank = 1'b0;
  endtask

  function automatic logic in_window(input int lat);
    return (lat >= SC + 4) && (lat <= SC + 6);
  endfunction

  typedef struct {
    int          idx;
    logic [15:0] val;
    int          hi;
    logic        use_force;
    int          exp_p1;
    logic        exp_pend1;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int base0, base1, nw;
    vecs[0] = '{3,  16'h1234, 3, 1'b0, 0, 1'b1};
    vecs[1] = '{0,  16'hBEEF, 2, 1'b0, 0, 1'b1};
    vecs[2] = '{7,  16'h00FF, 3, 1'b1, 1, 1'b0};
    vecs[3] = '{15, 16'hA5A5, 1, 1'b0, 0, 1'b1};

    reset = 1'b0;
    bus_en = 1'b0; bus_wr = 1'b0; vblank = 1'b0; force_update = 1'b0;
    for (int i = 0; i < NR; i++) values_in[reg_lsb(i, DW) +: DW] = DW'($urandom);
    idle(3);
    check("reset_vo0", vo0, '0);
    check("reset_vo1", vo1, '0);
    check("reset_pend", W'({pend0, pend1}), '0);
    check("reset_done", W'({done0, done1}), '0);
    reset = 1'b1;
    sh0 = '0; sh1 = '0;
    idle(3);

    // Directed single writes, table driven.
    for (int v = 0; v < 4; v++) begin
      base0 = pulses0; base1 = pulses1;
      do_write(vecs[v].idx, vecs[v].val, vecs[v].hi);
      if (vecs[v].use_force) pulse_force();
      idle(14);
      sh0 = values_in;
      check($sformatf("v%0d_lat0", v), W'(in_window(last_done0 - fall_cyc)), W'(1));
      check($sformatf("v%0d_pulses0", v), W'(pulses0 - base0), W'(1));
      check($sformatf("v%0d_reg0", v), W'(vo0[reg_lsb(vecs[v].idx, DW) +: DW]), W'(vecs[v].val));
      check($sformatf("v%0d_vo0", v), vo0, sh0);
      check($sformatf("v%0d_pend0", v), W'(pend0), W'(0));
      check($sformatf("v%0d_pulses1", v), W'(pulses1 - base1), W'(vecs[v].exp_p1));
      check($sformatf("v%0d_pend1", v), W'(pend1), W'(vecs[v].exp_pend1));
      if (vecs[v].use_force) begin
        sh1 = values_in;
        check($sformatf("v%0d_lat1", v), W'(in_window(last_done1 - fall_cyc)), W'(1));
        check($sformatf("v%0d_vo1_forced", v), vo1, sh1);
      end else begin
        idle(36);
        check($sformatf("v%0d_vo1_held", v), vo1, sh1);
        check($sformatf("v%0d_pend1_held", v), W'(pend1), W'(1));
        vblank_pulse();
        idle(4);
        sh1 = values_in;
        check($sformatf("v%0d_vo1_vblank", v), vo1, sh1);
        check($sformatf("v%0d_pend1_after", v), W'(pend1), W'(0));
        check($sformatf("v%0d_pulses1_vblank", v), W'(pulses1 - base1), W'(1));
      end
    end

    // Back-to-back writes to reg 1: one capture with the second value.
    base0 = pulses0;
    do_write(1, 16'h0001, 3);
    idle(1);
    do_write(1, 16'h0002, 3);
    idle(16);
    check("b2b_pulses0", W'(pulses0 - base0), W'(1));
    check("b2b_reg1", W'(vo0[reg_lsb(1, DW) +: DW]), W'(16'h0002));
    vblank_pulse();
    idle(4);
    sh1 = values_in;
    check("b2b_vo1", vo1, sh1);

    // Write becomes visible in the same cycle vblank rises while in ARM.
    base1 = pulses1;
    do_write(4, 16'h1111, 2);
    idle(15);
    @(negedge clk);
    bus_en = 1'b1; bus_wr = 1'b1;
    idle(2);
    vblank = 1'b1;
    @(negedge clk);
    bus_en = 1'b0; bus_wr = 1'b0;
    values_in[reg_lsb(4, DW) +: DW] = 16'h2222;
    idle(3);
    vblank = 1'b0;
    idle(15);
    check("race_no_capture", W'(pulses1 - base1), W'(0));
    check("race_vo1_held", vo1, sh1);
    check("race_pend1", W'(pend1), W'(1));
    vblank_pulse();
    idle(4);
    sh1 = values_in;
    check("race_reg4", W'(vo1[reg_lsb(4, DW) +: DW]), W'(16'h2222));
    check("race_vo1", vo1, sh1);
    check("race_pulses1", W'(pulses1 - base1), W'(1));
    sh0 = values_in;
    check("race_vo0", vo0, sh0);

    // force_update while idle with nothing pending stays latched.
    base0 = pulses0; base1 = pulses1;
    pulse_force();
    idle(20);
    check("idle_force_no_pulse", W'((pulses0 - base0) + (pulses1 - base1)), W'(0));
    do_write(9, 16'h0F0F, 2);
    idle(16);
    sh1 = values_in;
    check("idle_force_pulses1", W'(pulses1 - base1), W'(1));
    check("idle_force_vo1", vo1, sh1);

    // vblank with nothing pending does nothing.
    base1 = pulses1;
    vblank_pulse();
    idle(6);
    check("vblank_idle_no_pulse", W'(pulses1 - base1), W'(0));

    // Reset while settling discards the write.
    do_write(2, 16'hCAFE, 3);
    idle(3);
    reset = 1'b0;
    idle(2);
    check("rst_vo0", vo0, '0);
    check("rst_vo1", vo1, '0);
    check("rst_pend", W'({pend0, pend1}), '0);
    check("rst_done", W'({done0, done1}), '0);
    reset = 1'b1;
    base0 = pulses0; base1 = pulses1;
    idle(20);
    vblank_pulse();
    idle(6);
    check("rst_no_capture", W'((pulses0 - base0) + (pulses1 - base1)), W'(0));
    check("rst_vo1_zero", vo1, '0);
    do_write(2, 16'hCAFE, 3);
    idle(16);
    sh0 = values_in;
    check("rst_rewrite_vo0", vo0, sh0);
    vblank_pulse();
    idle(4);
    sh1 = values_in;
    check("rst_rewrite_vo1", vo1, sh1);

    // Random bursts against the shadow model.
    for (int it = 0; it < 20; it++) begin
      base0 = pulses0; base1 = pulses1;
      nw = $urandom_range(1, 3);
      for (int k = 0; k < nw; k++) begin
        do_write($urandom_range(0, NR - 1), DW'($urandom), $urandom_range(1, 4));
        if (k < nw - 1) idle($urandom_range(1, 3));
      end
      idle(16);
      sh0 = values_in;
      check($sformatf("rnd%0d_pulses0", it), W'(pulses0 - base0), W'(1));
      check($sformatf("rnd%0d_vo0", it), vo0, sh0);
      check($sformatf("rnd%0d_vo1_held", it), vo1, sh1);
      check($sformatf("rnd%0d_pend1", it), W'(pend1), W'(1));
      if ($urandom_range(0, 1) == 1) pulse_force();
      else vblank_pulse();
      idle(6);
      sh1 = values_in;
      check($sformatf("rnd%0d_vo1", it), vo1, sh1);
      check($sformatf("rnd%0d_pulses1", it), W'(pulses1 - base1), W'(1));
      check($sformatf("rnd%0d_pend1_clr", it), W'(pend1), W'(0));
    end

    check("no_spurious_change", W'(spur), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/reg_shadow_latch.md
Name: reg_shadow_latch

Overview:
- Consumes the flat register-value bus produced by the bus-clocked control register file. Those values change asynchronously to the system clock, on the falling edge of the bus write strobe.
- Detects bus write activity and waits for it to settle. It then snapshots all register values into a clk-domain shadow copy, optionally only at the start of vertical blank.
- Downstream rendering logic reads only the shadow copy. Its values are therefore glitch-free and constant for a whole frame.

Parameters:
DATA_WIDTH, 16, width of one register
NUM_REGS, 16, number of registers in the flat bus
SETTLE_CYCLES, 4, clk cycles of bus quiet required after a write before capture (1..255)
SYNC_TO_VBLANK, 1, 1 = capture only on vblank rising edge; 0 = capture as soon as settled

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
values_in  input  DATA_WIDTH*NUM_REGS  live register values; register i occupies bits [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]
bus_en  input  1  register bus access enable (asynchronous to clk)
bus_wr  input  1  register bus write strobe, active high (asynchronous; data is committed on its falling edge)
vblank  input  1  vertical blank flag, synchronous to clk
force_update  input  1  one-cycle request to capture as soon as settled, ignoring vblank
values_out  output  DATA_WIDTH*NUM_REGS  shadow copy, same packing as values_in
pending  output  1  a write has occurred that is not yet captured
update_done  output  1  one-cycle pulse in the cycle after a capture

Behaviour:
- Reset (reset low, asynchronous): values_out=0, pending=0, update_done=0, state IDLE, settle counter 0, synchronizer flops 0, force latch 0, vblank history 0.
- busy_raw = bus_en & bus_wr, passed through a 2-flop synchronizer to give busy_s. busy_d is busy_s delayed one cycle.
- Write end: fall = busy_d & ~busy_s. Write start: busy_s high.
- pending is set on the fall cycle and cleared on the capture cycle. If set and clear coincide, set wins.
- force_update is latched into force_req until a capture occurs. Reset clears force_req.
- vblank_rise = vblank & ~vblank_d.
- States:
  - IDLE: on fall, load cnt=SETTLE_CYCLES and go to SETTLE. If busy_s is high, stay in IDLE.
  - SETTLE: while busy_s is high, reload cnt and stay. Otherwise decrement cnt. When cnt==1 and busy_s is low, go to ARM.
  - ARM: if busy_s is high, go to SETTLE and reload cnt. Else if SYNC_TO_VBLANK==0, or force_req, or vblank_rise, go to CAPTURE. Otherwise wait in ARM.
  - CAPTURE: values_out <= values_in; clear pending and force_req; go to IDLE. update_done is high in the following cycle only.
- Latency with SYNC_TO_VBLANK=0 and a single write: update_done rises between SETTLE_CYCLES+4 and SETTLE_CYCLES+6 clk edges after bus_wr falls.
- A write (busy_s high) in the same cycle as vblank_rise while in ARM: the write wins, no capture occurs, and the capture is deferred to the next vblank.
- force_update in IDLE with pending=0: the request stays latched and is acted on after the next write settles. No spurious capture occurs.
- vblank_rise with pending=0: no capture and no pulse.
- values_out never changes outside CAPTURE.
- Reset asserted mid-SETTLE or mid-ARM: all state is discarded and the pending write is lost. The bench re-writes after reset.
- values_in is sampled only in CAPTURE, after at least SETTLE_CYCLES quiet cycles. No per-bit synchronization is required.

Decomposition:
- Shared package reg_shadow_pkg holds:
  - state enum: IDLE, SETTLE, ARM, CAPTURE (2 bits);
  - CNT_WIDTH = 8;
  - helper constant for flat-bus slice indexing.
- One sub-module, cc_sync2: a generic 2-flop synchronizer with parameter WIDTH and async active-low reset. It is reused for busy_raw.
- Everything else stays in reg_shadow_latch.

Test Plan:
1. SYNC_TO_VBLANK=0, SETTLE_CYCLES=4; write 0x1234 to reg 3, bus_wr pulse 3 cycles -> update_done pulses once within 8–10 edges of bus_wr falling; values_out reg3=0x1234; pending 1 then 0.
2. SYNC_TO_VBLANK=1; write 0xBEEF to reg 0, raise vblank 50 cycles later -> values_out unchanged and pending=1 until vblank rise; capture at CAPTURE cycle; update_done 1 cycle.
3. Back-to-back writes to reg 1 (0x0001, then 0x0002 two cycles after the first wr falls) -> exactly one update_done; reg1 shadow=0x0002.
4. Write with bus_wr high in the same cycle that vblank rises while in ARM -> no capture at that vblank; capture at the next vblank with the new value.
5. SYNC_TO_VBLANK=1, write 0x00FF to reg 7, pulse force_update -> capture without vblank within SETTLE_CYCLES+6 edges; force_req cleared.
6. Assert reset while in SETTLE after a write to reg 2 -> values_out=0, pending=0, update_done stays 0; a vblank after reset release produces no capture.
